keypad_encoder: RTL

- Front-end writer for the timer's load interface. Takes the ten raw digit keys of the microwave keypad.
- Synchronises and debounces the keys, then encodes them to BCD.
- For each accepted key press, drives data_out[3:0] plus an active-low loadn pulse; the timer's data_in/loadn ports consume these.
- One accepted press produces exactly one load. There is no auto-repeat.

---
 rtl/microondas_pkg.sv | 41 ++++
 rtl/keypad_encoder_if.sv | 16 +
 rtl/key_sync.sv | 28 ++
 rtl/keypad_encoder.sv | 121 ++++++++++++
 4 files changed

// File: rtl/microondas_pkg.sv
// Shared definitions for the microwave control front-end.
// Holds the keypad FSM state encoding, the keypad/BCD widths and the
// one-hot key encoder used by keypad_encoder.
package microondas_pkg;

    localparam int KEY_COUNT = 10;
    localparam int BCD_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_LOAD     = 3'd2,
        ST_HOLD     = 3'd3,
        ST_RELEASE  = 3'd4
    } key_state_t;

    typedef struct packed {
        logic             single;
        logic             none;
        logic [BCD_W-1:0] code;
    } key_enc_t;

    // code is only meaningful when single is set; with several keys down it
    // holds the highest index, which the FSM never looks at.
    function automatic key_enc_t encode_keys(input logic [KEY_COUNT-1:0] keys);
        key_enc_t r;
        int       n;
        r = '{single: 1'b0, none: 1'b0, code: '0};
        n = 0;
        for (int i = 0; i < KEY_COUNT; i++) begin
            if (keys[i]) begin
                n++;
                r.code = BCD_W'(i);
            end
        end
        r.single = (n == 1);
        r.none   = (n == 0);
        return r;
    endfunction

endpackage

// File: rtl/keypad_encoder_if.sv
// Load bus from the keypad front-end to the timer.
//   data_out : BCD digit of the last accepted key
//   loadn    : active-low load strobe
//   key_held : high from acceptance until debounced release
// master = keypad_encoder, slave = timer.
interface keypad_encoder_if;
    import microondas_pkg::*;

    logic [BCD_W-1:0] data_out;
    logic             loadn;
    logic             key_held;

    modport master (output data_out, output loadn, output key_held);
    modport slave  (input  data_out, input  loadn, input  key_held);

endinterface

// File: rtl/key_sync.sv
// Two-flop synchroniser, WIDTH bits wide, asynchronous active-low clear.
// Also intended for the start/stop/door inputs.
//   clock  : sampling clock
//   clearn : async active-low clear, both stages go to 0
//   d      : asynchronous inputs
//   q      : synchronised outputs (two clocks of latency)
module key_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             clearn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_encoder.sv
// Keypad front-end: synchronises and debounces the ten digit keys, encodes
// the accepted key to BCD and issues one loadn pulse per accepted press.
//   clock   : system clock
//   clearn  : async active-low reset
//   enable  : key activity ignored while low
//   keypad  : raw active-high key lines, bit i = digit i
//   load_if : data_out / loadn / key_held towards the timer
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | no key accepted, waiting for a single key
// ST_DEBOUNCE | candidate key must stay alone and unchanged for cnt cycles
// ST_LOAD     | loadn low, lcnt counts the remaining strobe cycles
// ST_HOLD     | key accepted and still down, other keys ignored
// ST_RELEASE  | all keys up, must stay up for cnt cycles before re-arming
module keypad_encoder
    import microondas_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOAD_CYCLES     = 1
) (
    input  logic                 clock,
    input  logic                 clearn,
    input  logic                 enable,
    input  logic [KEY_COUNT-1:0] keypad,
    keypad_encoder_if.master     load_if
);

    localparam logic [7:0] DEB_INIT  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] LOAD_INIT = 4'(LOAD_CYCLES - 1);

    logic [KEY_COUNT-1:0] ks;
    key_enc_t             enc;

    key_state_t       state;
    logic [BCD_W-1:0] cand;
    logic [7:0]       cnt;
    logic [3:0]       lcnt;
    logic [BCD_W-1:0] data_out_q;
    logic             loadn_q;
    logic             key_held_q;

    key_sync #(.WIDTH(KEY_COUNT)) u_sync (
        .clock  (clock),
        .clearn (clearn),
        .d      (keypad),
        .q      (ks)
    );

    assign enc = encode_keys(ks);

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            state      <= ST_IDLE;
            cand       <= '0;
            cnt        <= '0;
            lcnt       <= '0;
            data_out_q <= '0;
            loadn_q    <= 1'b1;
            key_held_q <= 1'b0;
        end else if (!enable) begin
            // data_out deliberately keeps the last digit
            state      <= ST_IDLE;
            loadn_q    <= 1'b1;
            key_held_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enc.single) begin
                        cand  <= enc.code;
                        cnt   <= DEB_INIT;
                        state <= ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!enc.single || enc.code != cand) begin
                        state <= ST_IDLE;
                    end else if (cnt == '0) begin
                        data_out_q <= cand;
                        loadn_q    <= 1'b0;
                        key_held_q <= 1'b1;
                        lcnt       <= LOAD_INIT;
                        state      <= ST_LOAD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_LOAD: begin
                    if (lcnt == '0) begin
                        loadn_q <= 1'b1;
                        state   <= ST_HOLD;
                    end else begin
                        lcnt <= lcnt - 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (enc.none) begin
                        cnt   <= DEB_INIT;
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!enc.none) begin
                        state <= ST_HOLD;
                    end else if (cnt == '0) begin
                        key_held_q <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign load_if.data_out = data_out_q;
    assign load_if.loadn    = loadn_q;
    assign load_if.key_held = key_held_q;

endmodule
